bus_addr_dec_tmo: RTL and testbench

BUS_ADDR_DEC_TMO -- requirements
Module: bus_addr_dec_tmo

---
 rtl/bus_addr_dec_tmo.sv | 121 ++++++++++++
 tb/tb_bus_addr_dec_tmo.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/bus_addr_dec_tmo.sv
// rtl/bus_addr_dec_tmo.sv - bus address decoder with chip selects and access timeout
// Optional timeout counter enabled by defining BUS_ADDR_DEC_TMO_EN.
module bus_addr_dec_tmo #(
    parameter int WORD_ADDR_WIDTH = 30,
    parameter int SLAVE_NUM       = 8,
    parameter int SEL_WIDTH       = 3,
    parameter int TMO_CYCLES      = 255
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [WORD_ADDR_WIDTH-1:0] s_addr,
    input  logic                       s_as_n,
    input  logic                       s_rdy_n,
    output logic [SLAVE_NUM-1:0]       s_cs_n,
    output logic                       m_rdy_n,
    output logic                       m_err,
    output logic                       busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ERROR
    } state_t;

    state_t               state, state_nx;
    logic [SEL_WIDTH-1:0] idx, idx_q, idx_nx;
    logic                 mapped;
    logic                 timeout;
    logic [SLAVE_NUM-1:0] cs_nx;
    logic                 rdy_nx, err_nx, busy_nx;
    logic                 unused_addr;

    assign idx         = s_addr[WORD_ADDR_WIDTH-1 -: SEL_WIDTH];
    assign mapped      = (32'(idx) < SLAVE_NUM);
    assign unused_addr = ^s_addr;

`ifdef BUS_ADDR_DEC_TMO_EN
    localparam int CNT_W = $clog2(TMO_CYCLES + 1);
    logic [CNT_W-1:0] cnt;

    // Held at zero while idle, so every ACCESS starts counting from 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (state != ACCESS) begin
            cnt <= '0;
        end else if (cnt != CNT_W'(TMO_CYCLES)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign timeout = (cnt == CNT_W'(TMO_CYCLES - 1));
`else
    localparam int unused_tmo_cycles = TMO_CYCLES;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        idx_nx   = idx_q;
        cs_nx    = '1;
        rdy_nx   = 1'b1;
        err_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (!s_as_n) begin
                    if (mapped) begin
                        state_nx = ACCESS;
                        idx_nx   = idx;
                        cs_nx    = ~(SLAVE_NUM'(1) << idx);
                    end else begin
                        state_nx = ERROR;
                        err_nx   = 1'b1;
                        rdy_nx   = 1'b0;
                    end
                end
            end
            ACCESS: begin
                cs_nx = ~(SLAVE_NUM'(1) << idx_q);
                // Ready is tested first so it wins over a coincident timeout.
                if (!s_rdy_n) begin
                    state_nx = IDLE;
                    cs_nx    = '1;
                    rdy_nx   = 1'b0;
                end else if (timeout) begin
                    state_nx = ERROR;
                    cs_nx    = '1;
                    err_nx   = 1'b1;
                    rdy_nx   = 1'b0;
                end
            end
            ERROR: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            idx_q   <= '0;
            s_cs_n  <= '1;
            m_rdy_n <= 1'b1;
            m_err   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nx;
            idx_q   <= idx_nx;
            s_cs_n  <= cs_nx;
            m_rdy_n <= rdy_nx;
            m_err   <= err_nx;
            busy    <= busy_nx;
        end
    end

endmodule

// File: tb/tb_bus_addr_dec_tmo.sv
// tb/tb_bus_addr_dec_tmo.sv - randomized self-checking bench for bus_addr_dec_tmo
// Instance a: default parameters; instance b: SLAVE_NUM=6, TMO_CYCLES=4.
module tb_bus_addr_dec_tmo;

`ifdef BUS_ADDR_DEC_TMO_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [29:0] addr_a, addr_b;
    logic        as_a, as_b, rdy_a, rdy_b;
    logic [7:0]  cs_a;
    logic [5:0]  cs_b;
    logic        mrdy_a, mrdy_b, err_a, err_b, busy_a, busy_b;
    int          sel;
    int          n_checks = 0;
    int          n_fail   = 0;

    bus_addr_dec_tmo dut_a (
        .clk(clk), .reset_n(reset_n), .s_addr(addr_a), .s_as_n(as_a), .s_rdy_n(rdy_a),
        .s_cs_n(cs_a), .m_rdy_n(mrdy_a), .m_err(err_a), .busy(busy_a)
    );

    bus_addr_dec_tmo #(.SLAVE_NUM(6), .TMO_CYCLES(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .s_addr(addr_b), .s_as_n(as_b), .s_rdy_n(rdy_b),
        .s_cs_n(cs_b), .m_rdy_n(mrdy_b), .m_err(err_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [29:0] a, input logic as_n, input logic rdy_n);
        if (sel == 0) begin
            addr_a = a; as_a = as_n; rdy_a = rdy_n;
            addr_b = '0; as_b = 1'b1; rdy_b = 1'b1;
        end else begin
            addr_b = a; as_b = as_n; rdy_b = rdy_n;
            addr_a = '0; as_a = 1'b1; rdy_a = 1'b1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [7:0] cs, input logic mrdy,
                             input logic merr, input logic bsy);
        logic [7:0] cs_o;
        int         zeros;
        cs_o  = (sel == 0) ? cs_a : {2'b11, cs_b};
        zeros = 0;
        for (int i = 0; i < 8; i++) if (cs_o[i] == 1'b0) zeros++;
        check({tag, "_cs"}, 32'(cs_o), 32'(cs));
        check({tag, "_m_rdy_n"}, 32'((sel == 0) ? mrdy_a : mrdy_b), 32'(mrdy));
        check({tag, "_m_err"}, 32'((sel == 0) ? err_a : err_b), 32'(merr));
        check({tag, "_busy"}, 32'((sel == 0) ? busy_a : busy_b), 32'(bsy));
        check({tag, "_onehot"}, 32'(zeros <= 1), 32'd1);
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            set_in(30'($urandom), 1'b1, 1'($urandom));
            step();
            check_out("idle", 8'hFF, 1'b1, 1'b0, 1'b0);
        end
    endtask

    // Expected cycle sequence is derived from the decode rules: the ACCESS phase
    // lasts until the ready cycle, capped at the timeout length when enabled.
    task automatic xfer(input logic [29:0] a, input int rdy_at);
        int         n, tmo, len;
        bit         mapped, tmo_hit;
        logic [2:0] ix;
        logic [7:0] cs_exp;
        n       = (sel == 0) ? 8 : 6;
        tmo     = (sel == 0) ? 255 : 4;
        ix      = a[29:27];
        mapped  = int'(ix) < n;
        cs_exp  = ~(8'b1 << ix);
        tmo_hit = mapped && TMO_EN && (rdy_at > tmo);
        len     = !mapped ? 0 : (tmo_hit ? tmo : rdy_at);
        set_in(a, 1'b0, 1'($urandom));
        step();
        for (int k = 1; k <= len; k++) begin
            check_out("access", cs_exp, 1'b1, 1'b0, 1'b1);
            set_in(30'($urandom), 1'($urandom), (k == rdy_at) ? 1'b0 : 1'b1);
            step();
        end
        if (!mapped || tmo_hit) begin
            check_out("error", 8'hFF, 1'b0, 1'b1, 1'b1);
            set_in(30'($urandom), 1'($urandom), 1'($urandom));
            step();
            check_out("post_err", 8'hFF, 1'b1, 1'b0, 1'b0);
        end else begin
            check_out("done", 8'hFF, 1'b0, 1'b0, 1'b0);
            set_in(30'($urandom), 1'b1, 1'($urandom));
            step();
            check_out("post_done", 8'hFF, 1'b1, 1'b0, 1'b0);
        end
        set_in(30'($urandom), 1'b1, 1'($urandom));
    endtask

    initial begin
        reset_n = 1'b0;
        sel     = 0;
        set_in('0, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        sel = 0; check_out("reset_a", 8'hFF, 1'b1, 1'b0, 1'b0);
        sel = 1; check_out("reset_b", 8'hFF, 1'b1, 1'b0, 1'b0);
        sel = 0;
        reset_n = 1'b1;

        // Strobe on the first edge after reset release, idx 0, ready in 3rd cycle.
        xfer(30'h0300_0000, 3);

        // Unmapped index on the 6-slave instance.
        sel = 1;
        xfer({3'd7, 27'h123_4567}, 2);
        xfer({3'd6, 27'h000_0001}, 1);

        // Ready held off: timeout (enabled) or long wait (disabled).
        xfer({3'd3, 27'h0}, 20);
        // Ready on the 4th cycle coincides with the timeout: ready wins.
        xfer({3'd1, 27'h0}, 4);
        sel = 0;
        xfer({3'd5, 27'h0}, 1005);

        // Reset in the 2nd ACCESS cycle aborts silently.
        set_in({3'd2, 27'h0}, 1'b0, 1'b1);
        step();
        check_out("rst_acc1", ~8'h04, 1'b1, 1'b0, 1'b1);
        set_in(30'($urandom), 1'b1, 1'b1);
        step();
        check_out("rst_acc2", ~8'h04, 1'b1, 1'b0, 1'b1);
        reset_n = 1'b0;
        #1;
        check_out("rst_now", 8'hFF, 1'b1, 1'b0, 1'b0);
        set_in(30'($urandom), 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step();
            check_out("rst_hold", 8'hFF, 1'b1, 1'b0, 1'b0);
        end
        reset_n = 1'b1;
        xfer({3'd4, 27'h55}, 2);

        // Sweep every index on both instances.
        for (int s = 0; s < 2; s++) begin
            sel = s;
            for (int i = 0; i < 8; i++) begin
                xfer({3'(i), 27'($urandom)}, $urandom_range(1, 3));
                idle_gap($urandom_range(0, 1));
            end
        end

        // Randomized traffic.
        for (int s = 0; s < 2; s++) begin
            sel = s;
            for (int t = 0; t < 30; t++) begin
                xfer(30'($urandom), $urandom_range(1, 6));
                idle_gap($urandom_range(0, 2));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
